// File: rtl/verilog_test_pkg.sv
// Shared definitions for the signature-capture block: FSM states and MISR constants.
package verilog_test_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    localparam logic [15:0] MISR_POLY = 16'h1021;
endpackage

// File: rtl/verilog_misr_step.sv
// One combinational MISR step: shift left, fold in the polynomial on MSB carry-out,
// then XOR the three sampled inputs into the low bits.
module verilog_misr_step
    import verilog_test_pkg::*;
#(
    parameter int SIG_W = 16
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic [2:0]       i_data,
    output logic [SIG_W-1:0] o_sig_next
);
    logic [SIG_W-1:0] w_poly;

    assign w_poly     = i_sig[SIG_W-1] ? SIG_W'(MISR_POLY) : '0;
    assign o_sig_next = {i_sig[SIG_W-2:0], 1'b0} ^ w_poly ^ SIG_W'(i_data);
endmodule

// File: rtl/verilog_sig_capture.sv
// Capture a MISR signature of three upstream register outputs over N cycles and
// flag any input that never toggled during the run.
module verilog_sig_capture
    import verilog_test_pkg::*;
#(
    parameter int SIG_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [2:0]       stuck,
    output logic [CNT_W-1:0] remaining
);
    state_t           r_state;
    logic [SIG_W-1:0] r_sig;
    logic [CNT_W-1:0] r_remaining;
    logic [2:0]       r_seen_one;
    logic [2:0]       r_seen_zero;

    logic [2:0]       w_data;
    logic [SIG_W-1:0] w_sig_next;

    assign w_data = {in3, in2, in1};

    verilog_misr_step #(.SIG_W(SIG_W)) u_misr_step (
        .i_sig      (r_sig),
        .i_data     (w_data),
        .o_sig_next (w_sig_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sig       <= SIG_W'(MISR_SEED);
            r_remaining <= '0;
            r_seen_one  <= '0;
            r_seen_zero <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_sig       <= SIG_W'(MISR_SEED);
                        r_remaining <= num_cycles;
                        r_seen_one  <= '0;
                        r_seen_zero <= '0;
                        r_state     <= (num_cycles != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    r_sig       <= w_sig_next;
                    r_seen_one  <= r_seen_one | w_data;
                    r_seen_zero <= r_seen_zero | ~w_data;
                    // Saturate at zero so the count can never wrap.
                    if (r_remaining != '0)
                        r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining <= CNT_W'(1))
                        r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign signature = r_sig;
    assign remaining = r_remaining;
    // An input is stuck unless both levels were observed; an empty run sees neither.
    assign stuck     = done ? ~(r_seen_one & r_seen_zero) : 3'b000;
endmodule

// File: tb/tb_verilog_sig_capture.sv
// Self-checking bench for verilog_sig_capture: directed table, reset corner and
// randomized runs against a behavioural signature/stuck model.
module tb_verilog_sig_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_cycles;
    logic        in1, in2, in3;
    logic        busy, done;
    logic [15:0] signature;
    logic [2:0]  stuck;
    logic [7:0]  remaining;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] samples [256];

    verilog_sig_capture #(.SIG_W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_cycles (num_cycles),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .stuck      (stuck),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signature is a polynomial fold over the sample stream from the seed.
    function automatic logic [15:0] model_sig(input int n);
        int s = 32'hFFFF;
        for (int j = 0; j < n; j++) begin
            s = s * 2;
            if (s >= 32'h10000) s = (s - 32'h10000) ^ 32'h1021;
            s = s ^ int'(samples[j]);
        end
        return 16'(s);
    endfunction

    // Reference: an input is stuck if it was 1 on none or on all of the samples.
    function automatic logic [2:0] model_stuck(input int n);
        logic [2:0] r;
        for (int b = 0; b < 3; b++) begin
            int ones = 0;
            for (int j = 0; j < n; j++) ones += int'(samples[j][b]);
            r[b] = (ones == 0) || (ones == n);
        end
        return r;
    endfunction

    task automatic run_capture(input int n, input logic [15:0] exp_sig,
                               input logic [2:0] exp_stk, input bit poke);
        int busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        num_cycles = 8'(n);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < n; j++) begin
            chk("remaining_run", 32'(remaining), 32'(n - j));
            if (busy) busy_cnt++;
            {in3, in2, in1} = samples[j];
            if (poke && j == 1) begin
                start = 1'b1;
                num_cycles = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("busy_cycles", 32'(busy_cnt), 32'(n));
        chk("signature", 32'(signature), 32'(exp_sig));
        chk("stuck", 32'(stuck), 32'(exp_stk));
        chk("remaining_done", 32'(remaining), 32'd0);
        repeat (3) begin
            {in3, in2, in1} = 3'($urandom);
            @(negedge clk);
        end
        chk("hold_sig", 32'(signature), 32'(exp_sig));
        chk("hold_stuck", 32'(stuck), 32'(exp_stk));
        chk("hold_done", 32'(done), 32'd1);
    endtask

    typedef struct {
        int         n;
        logic [2:0] s [4];
        logic [15:0] sig;
        logic [2:0] stk;
    } vec_t;

    vec_t vecs [5];

    initial begin
        rst = 1'b1; start = 1'b0; num_cycles = '0;
        {in3, in2, in1} = 3'b000;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sig", 32'(signature), 32'hFFFF);
        chk("rst_stuck", 32'(stuck), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{1, '{3'b000, 3'b000, 3'b000, 3'b000}, 16'hEFDF, 3'b111};
        vecs[1] = '{1, '{3'b101, 3'b000, 3'b000, 3'b000}, 16'hEFDA, 3'b111};
        vecs[2] = '{2, '{3'b000, 3'b000, 3'b000, 3'b000}, 16'hCF9F, 3'b111};
        vecs[3] = '{4, '{3'b010, 3'b011, 3'b010, 3'b011}, 16'h0E04, 3'b110};
        vecs[4] = '{0, '{3'b000, 3'b000, 3'b000, 3'b000}, 16'hFFFF, 3'b111};
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < 4; j++) samples[j] = vecs[v].s[j];
            run_capture(vecs[v].n, vecs[v].sig, vecs[v].stk, 1'b0);
        end

        // Mid-run reset: abandon immediately, ignore start while held.
        for (int j = 0; j < 10; j++) samples[j] = 3'($urandom);
        @(negedge clk);
        start = 1'b1; num_cycles = 8'd10;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            {in3, in2, in1} = samples[j];
            @(negedge clk);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_sig", 32'(signature), 32'hFFFF);
        chk("async_remaining", 32'(remaining), 32'd0);
        chk("async_stuck", 32'(stuck), 32'd0);
        start = 1'b1; num_cycles = 8'd5;
        @(negedge clk);
        chk("rst_start_ignored", 32'({busy, done}), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        samples[0] = 3'b000;
        run_capture(1, 16'hEFDF, 3'b111, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int n = int'($urandom_range(1, 24));
            int mode [3];
            for (int b = 0; b < 3; b++) mode[b] = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++)
                for (int b = 0; b < 3; b++)
                    samples[j][b] = (mode[b] == 2) ? 1'($urandom) : 1'(mode[b]);
            run_capture(n, model_sig(n), model_stuck(n), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/verilog_sig_capture.md
VERILOG_SIG_CAPTURE -- requirements
Module: verilog_sig_capture

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- SIG_W, 16, MISR signature width
- CNT_W, 8, sample-count width
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a capture run; honoured in IDLE and DONE only.
REQ-005 num_cycles  input  CNT_W  samples per run; sampled only when start is accepted.
REQ-006 in1, in2, in3  input  1 each  registered outputs of the upstream register stage (its out1, out2, out3).
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  high while in DONE.
REQ-009 signature  output  SIG_W  current MISR contents.
REQ-010 stuck  output  3  per-input stuck flag; bit0=in1, bit1=in2, bit2=in3; valid when done=1.
REQ-011 remaining  output  CNT_W  samples still to take in the current run.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 Transitions:
- IDLE/DONE + start with num_cycles!=0 -> RUN
- IDLE/DONE + start with num_cycles==0 -> DONE
- RUN with remaining==1 at an edge -> DONE
- otherwise hold state
REQ-014 On start acceptance:
- signature = 16'hFFFF
- remaining = num_cycles
- per-input seen-one and seen-zero flags cleared
REQ-015 At each RUN edge:
- signature_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {13'b0,in3,in2,in1}
- remaining decrements by 1
- seen-one/seen-zero flags OR in the current input values
REQ-016 stuck[i] SHALL equal NOT(seen_one[i] AND seen_zero[i]); a zero-length run reports stuck=3'b111.
REQ-017 Latency: with start accepted at edge k and num_cycles=N>0, samples are taken at edges k+1..k+N and done rises after edge k+N.
REQ-018 start during RUN SHALL be ignored; the run completes unchanged.
REQ-019 In DONE, signature, stuck and remaining (0) SHALL hold until start is accepted or rst is asserted.
REQ-020 remaining SHALL never wrap below 0; the counter arithmetic is CNT_W-bit unsigned.

Reset
REQ-021 rst SHALL force the following immediately, without waiting for clk:
- state = IDLE
- busy = 0, done = 0
- signature = 16'hFFFF, stuck = 3'b000, remaining = 0
REQ-022 rst asserted mid-run SHALL abandon the run with no partial result retained; start is not honoured while rst is high.

Structure
REQ-023 A shared package verilog_test_pkg SHALL hold:
- the FSM state enum
- MISR_SEED (16'hFFFF)
- MISR_POLY (16'h1021)
REQ-024 The MISR update SHALL be a single sub-module, verilog_misr_step, which is combinational: signature, data -> next signature. All sequential logic stays in verilog_sig_capture.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- start, N=1, inputs 3'b000 -> done after 2 edges, signature 16'hEFDF, stuck 3'b111.
- start, N=1, {in3,in2,in1}=3'b101 -> signature 16'hEFDA.
- start, N=2, inputs 0 both samples -> signature 16'hCF9F, busy high for exactly 2 cycles.
- start, N=4, in1 toggling 0,1,0,1, in2=1, in3=0 -> stuck 3'b110.
- start, N=0 -> done next cycle, signature 16'hFFFF, busy never high.
- rst pulsed mid-run (N=10, after 3 samples) -> immediate IDLE, signature 16'hFFFF, remaining 0; a new start with N=1, inputs 0 -> 16'hEFDF.
